pc_sequencer: RTL

- Owns the program counter register and sequences the shared 16-bit PC adder (pc + operand) for instruction fetch.
- Each instruction: one fetch handshake with instruction memory, then one update cycle in which the adder produces pc+INC or pc+branch_offset, or a jump target bypasses the adder.
- Sits between the decode stage (branch/jump/stall/halt inputs) and instruction memory.

---
 rtl/pc_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences the shared PC adder
// through one fetch handshake followed by one PC update per instruction.
//
// Ports:
//   clock          in   system clock, rising-edge state updates
//   reset          in   asynchronous active-low reset
//   imem_ack       in   instruction memory accepted/returned the fetch
//   stall          in   decode hold request (UPDATE only)
//   halt           in   stop fetching (UPDATE only)
//   branch_taken   in   PC-relative branch (UPDATE only)
//   branch_offset  in   two's-complement branch offset
//   jump           in   absolute jump (UPDATE only)
//   jump_target    in   absolute jump address
//   add_sum        in   shared adder result, add_a + add_b
//   add_a          out  adder operand A (pc)
//   add_b          out  adder operand B, combinational
//   pc             out  program counter / imem address
//   imem_req       out  fetch request, high in FETCH
//   fetch_valid    out  one-cycle pulse after an accepted ack
//   halted         out  high in HALT
//   fetch_error    out  sticky ack-timeout / alignment fault flag
//
// Optional build macro: PC_ALIGN_CHECK_EN -- when defined, an odd jump or
// branch target is refused: pc holds, fetch_error sets and the block halts.

module pc_sequencer #(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      INC         = 2,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned      ACK_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             imem_ack,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] add_sum,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic [WIDTH-1:0] pc,
    output logic             imem_req,
    output logic             fetch_valid,
    output logic             halted,
    output logic             fetch_error
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2,
        HALT   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               imem_req_q, imem_req_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic               halted_q, halted_d;
    logic               fetch_error_q, fetch_error_d;
    logic [WIDTH-1:0]   new_pc;

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            cnt_q         <= '0;
            imem_req_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            imem_req_q    <= imem_req_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
            fetch_error_q <= fetch_error_d;
        end
    end

    // Next-state, next-pc and next-output logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        fetch_valid_d = 1'b0;
        fetch_error_d = fetch_error_q;
        // The adder already holds pc+INC or pc+offset; only a jump bypasses it.
        new_pc        = jump ? jump_target : add_sum;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end

            FETCH: begin
                if (imem_ack) begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    fetch_valid_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = UPDATE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    fetch_error_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            UPDATE: begin
                if (halt) begin
                    state_d = HALT;
                end else if (stall) begin
                    state_d = UPDATE;
                end else begin
`ifdef PC_ALIGN_CHECK_EN
                    if ((jump || branch_taken) && new_pc[0]) begin
                        fetch_error_d = 1'b1;
                        state_d       = HALT;
                    end else begin
                        pc_d    = new_pc;
                        state_d = FETCH;
                    end
`else
                    pc_d    = new_pc;
                    state_d = FETCH;
`endif
                end
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = BOOT;
            end
        endcase

        imem_req_d = (state_d == FETCH);
        halted_d   = (state_d == HALT);
    end

    // Operand B follows branch_taken combinationally so the sum is ready in UPDATE
    assign add_b = ((state_q == UPDATE) && branch_taken) ? branch_offset : WIDTH'(INC);

    assign add_a       = pc_q;
    assign pc          = pc_q;
    assign imem_req    = imem_req_q;
    assign fetch_valid = fetch_valid_q;
    assign halted      = halted_q;
    assign fetch_error = fetch_error_q;

endmodule
